// File: rtl/calc_pkg.sv
// Shared types and constants for the calc port responder.
// Command/response codes, FSM states, data width.
package calc_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GET_OP2 = 2'd1,
    S_RESP    = 2'd2
  } state_e;

  // True for commands that take two operands.
  function automatic logic cmd_valid(
    input logic [3:0] cmd,
    input logic       en_shift
  );
    logic ok;
    ok = 1'b0;
    unique case (cmd)
      CMD_ADD, CMD_SUB: ok = 1'b1;
      CMD_SHL, CMD_SHR: ok = en_shift;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational datapath for the calc port responder.
// Add/sub flag carry and borrow; shifts never error.
module calc_alu
  import calc_pkg::*;
#(
  parameter bit ENABLE_SHIFT = 1'b1
) (
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output resp_e             resp,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W:0] sum;
  logic [4:0]      shamt;

  assign sum   = {1'b0, op1} + {1'b0, op2};
  assign shamt = op2[4:0];

  // Select the result and response for the captured command.
  always_comb begin
    resp = RESP_ERR;
    data = '0;
    if (cmd_valid(cmd, ENABLE_SHIFT)) begin
      unique case (cmd)
        CMD_ADD: begin
          if (!sum[DATA_W]) begin
            resp = RESP_OK;
            data = sum[DATA_W-1:0];
          end
        end
        CMD_SUB: begin
          if (op1 >= op2) begin
            resp = RESP_OK;
            data = op1 - op2;
          end
        end
        CMD_SHL: begin
          resp = RESP_OK;
          data = op1 << shamt;
        end
        CMD_SHR: begin
          resp = RESP_OK;
          data = op1 >> shamt;
        end
        default: begin
          resp = RESP_ERR;
          data = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/calc_port_responder.sv
// Two-operand command responder with one-cycle response.
// Invalid commands answer immediately, valid ones after op2.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter bit ENABLE_SHIFT = 1'b1
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data
);

  logic [3:0]        cmd_in;
  logic [DATA_W-1:0] din;

  assign cmd_in = req_cmd_in;
  assign din    = req_data_in;

  state_e            state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  resp_e             resp_q, resp_d;
  logic [DATA_W-1:0] data_q, data_d;

  resp_e             alu_resp;
  logic [DATA_W-1:0] alu_data;

  calc_alu #(
    .ENABLE_SHIFT(ENABLE_SHIFT)
  ) u_alu (
    .cmd  (cmd_q),
    .op1  (op1_q),
    .op2  (din),
    .resp (alu_resp),
    .data (alu_data)
  );

  // State and captured operands; reset aborts any transaction.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      resp_q  <= RESP_NONE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
    end
  end

  // Next state; RESP also accepts a new command edge.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    resp_d  = RESP_NONE;
    data_d  = '0;
    unique case (state_q)
      S_GET_OP2: begin
        op2_d   = din;
        resp_d  = alu_resp;
        data_d  = alu_data;
        state_d = S_RESP;
      end
      default: begin
        if (cmd_in == CMD_NOP) begin
          state_d = S_IDLE;
        end else if (cmd_valid(cmd_in, ENABLE_SHIFT)) begin
          cmd_d   = cmd_in;
          op1_d   = din;
          state_d = S_GET_OP2;
        end else begin
          resp_d  = RESP_ERR;
          state_d = S_RESP;
        end
      end
    endcase
  end

  assign out_resp = resp_q;
  assign out_data = data_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder.
// Second instance runs with shifts disabled.
module tb_calc_port_responder;

  logic        c_clk;
  logic        reset;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic [0:1]  ns_resp;
  logic [0:31] ns_data;

  int checks;
  int errors;

  calc_port_responder #(.ENABLE_SHIFT(1'b1)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data)
  );

  calc_port_responder #(.ENABLE_SHIFT(1'b0)) dut_ns (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (ns_resp),
    .out_data    (ns_data)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic step(input logic [3:0] c, input logic [31:0] d);
    req_cmd_in  = c;
    req_data_in = d;
    @(posedge c_clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_cmd_in = 4'd0;
    req_data_in = 32'd0;
    #1;
    checks++;
    if ({out_resp, out_data} !== 34'd0) begin
      errors++;
      $display("FAIL reset_async: resp=%0d data=%h want 0/0", out_resp, out_data);
    end
    step(4'd1, 32'h1);
    step(4'd0, 32'h1);
    checks++;
    if ({out_resp, out_data} !== 34'd0) begin
      errors++;
      $display("FAIL reset_held: resp=%0d data=%h want 0/0", out_resp, out_data);
    end
    #2 reset = 1'b0;
    step(4'd0, 32'h0);
  endtask

  task automatic test_add;
    step(4'd1, 32'h0000_0001);
    checks++;
    if ({out_resp, out_data} !== 34'd0) begin
      errors++;
      $display("FAIL add_e0: resp=%0d data=%h want 0/0", out_resp, out_data);
    end
    step(4'd0, 32'h1FFF_FFFF);
    checks++;
    if ({out_resp, out_data} !== {2'd1, 32'h2000_0000}) begin
      errors++;
      $display("FAIL add_resp: resp=%0d data=%h want 1/20000000", out_resp, out_data);
    end
    step(4'd0, 32'h0);
    checks++;
    if ({out_resp, out_data} !== 34'd0) begin
      errors++;
      $display("FAIL add_clear: resp=%0d data=%h want 0/0", out_resp, out_data);
    end
  endtask

  task automatic test_overflow;
    step(4'd1, 32'hFFFF_FFFF);
    step(4'd0, 32'h0000_0001);
    checks++;
    if ({out_resp, out_data} !== {2'd2, 32'h0}) begin
      errors++;
      $display("FAIL add_ovf: resp=%0d data=%h want 2/0", out_resp, out_data);
    end
    step(4'd2, 32'd1);
    step(4'd0, 32'd15);
    checks++;
    if ({out_resp, out_data} !== {2'd2, 32'h0}) begin
      errors++;
      $display("FAIL sub_unf: resp=%0d data=%h want 2/0", out_resp, out_data);
    end
    step(4'd2, 32'd7);
    step(4'd0, 32'd7);
    checks++;
    if ({out_resp, out_data} !== {2'd1, 32'h0}) begin
      errors++;
      $display("FAIL sub_eq: resp=%0d data=%h want 1/0", out_resp, out_data);
    end
    step(4'd2, 32'd10);
    step(4'd0, 32'd3);
    checks++;
    if ({out_resp, out_data} !== {2'd1, 32'd7}) begin
      errors++;
      $display("FAIL sub_ok: resp=%0d data=%h want 1/7", out_resp, out_data);
    end
    step(4'd0, 32'd0);
  endtask

  task automatic test_invalid;
    step(4'd3, 32'd1);
    checks++;
    if ({out_resp, out_data} !== {2'd2, 32'h0}) begin
      errors++;
      $display("FAIL inv_3: resp=%0d data=%h want 2/0", out_resp, out_data);
    end
    step(4'd4, 32'd1);
    checks++;
    if ({out_resp, out_data} !== {2'd2, 32'h0}) begin
      errors++;
      $display("FAIL inv_4: resp=%0d data=%h want 2/0", out_resp, out_data);
    end
    step(4'd0, 32'd0);
    checks++;
    if ({out_resp, out_data} !== 34'd0) begin
      errors++;
      $display("FAIL inv_clear: resp=%0d data=%h want 0/0", out_resp, out_data);
    end
    step(4'd1, 32'd5);
    step(4'd0, 32'd6);
    checks++;
    if ({out_resp, out_data} !== {2'd1, 32'd11}) begin
      errors++;
      $display("FAIL inv_after: resp=%0d data=%h want 1/b", out_resp, out_data);
    end
    step(4'd0, 32'd0);
  endtask

  task automatic test_shift;
    step(4'd5, 32'h0000_0001);
    checks++;
    if ({ns_resp, ns_data} !== {2'd2, 32'h0}) begin
      errors++;
      $display("FAIL ns_shl: resp=%0d data=%h want 2/0", ns_resp, ns_data);
    end
    step(4'd0, 32'h0000_0023);
    checks++;
    if ({out_resp, out_data} !== {2'd1, 32'h0000_0008}) begin
      errors++;
      $display("FAIL shl_3: resp=%0d data=%h want 1/8", out_resp, out_data);
    end
    step(4'd6, 32'h8000_0000);
    checks++;
    if ({ns_resp, ns_data} !== {2'd2, 32'h0}) begin
      errors++;
      $display("FAIL ns_shr: resp=%0d data=%h want 2/0", ns_resp, ns_data);
    end
    step(4'd0, 32'd31);
    checks++;
    if ({out_resp, out_data} !== {2'd1, 32'h0000_0001}) begin
      errors++;
      $display("FAIL shr_31: resp=%0d data=%h want 1/1", out_resp, out_data);
    end
    step(4'd5, 32'hFFFF_FFFF);
    step(4'd0, 32'hFFFF_FFE4);
    checks++;
    if ({out_resp, out_data} !== {2'd1, 32'hFFFF_FFF0}) begin
      errors++;
      $display("FAIL shl_hi: resp=%0d data=%h want 1/fffffff0", out_resp, out_data);
    end
    step(4'd0, 32'd0);
  endtask

  task automatic test_back_to_back;
    step(4'd1, 32'd10);
    step(4'd0, 32'd20);
    checks++;
    if ({out_resp, out_data} !== {2'd1, 32'd30}) begin
      errors++;
      $display("FAIL b2b_first: resp=%0d data=%h want 1/1e", out_resp, out_data);
    end
    step(4'd1, 32'd100);
    checks++;
    if ({out_resp, out_data} !== 34'd0) begin
      errors++;
      $display("FAIL b2b_gap: resp=%0d data=%h want 0/0", out_resp, out_data);
    end
    step(4'd0, 32'd5);
    checks++;
    if ({out_resp, out_data} !== {2'd1, 32'd105}) begin
      errors++;
      $display("FAIL b2b_second: resp=%0d data=%h want 1/69", out_resp, out_data);
    end
    step(4'd0, 32'hDEAD_BEEF);
    step(4'd0, 32'hFFFF_FFFF);
    checks++;
    if ({out_resp, out_data} !== 34'd0) begin
      errors++;
      $display("FAIL nop_data: resp=%0d data=%h want 0/0", out_resp, out_data);
    end
  endtask

  task automatic test_reset_abort;
    step(4'd1, 32'd1);
    step(4'd0, 32'd2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_resp, out_data} !== 34'd0) begin
      errors++;
      $display("FAIL rst_resp: resp=%0d data=%h want 0/0", out_resp, out_data);
    end
    #2 reset = 1'b0;
    step(4'd1, 32'd1);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    step(4'd0, 32'd5);
    checks++;
    if ({out_resp, out_data} !== 34'd0) begin
      errors++;
      $display("FAIL rst_abort: resp=%0d data=%h want 0/0", out_resp, out_data);
    end
    step(4'd0, 32'd0);
    checks++;
    if ({out_resp, out_data} !== 34'd0) begin
      errors++;
      $display("FAIL rst_quiet: resp=%0d data=%h want 0/0", out_resp, out_data);
    end
    step(4'd1, 32'd2);
    step(4'd0, 32'd3);
    checks++;
    if ({out_resp, out_data} !== {2'd1, 32'd5}) begin
      errors++;
      $display("FAIL rst_after: resp=%0d data=%h want 1/5", out_resp, out_data);
    end
    step(4'd0, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_overflow();
    test_invalid();
    test_shift();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_port_responder.md
CALC_PORT_RESPONDER -- requirements
Module: calc_port_responder

Interface
REQ-001 The block SHALL have parameter ENABLE_SHIFT, default 1; 1 enables commands 5/6, 0 makes them invalid.
REQ-002 The block SHALL have port c_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req_cmd_in, input, [0:3], command: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right; all other values are invalid.
REQ-005 The block SHALL have port req_data_in, input, [0:31], operand 1 in the command cycle and operand 2 in the following cycle.
REQ-006 The block SHALL have port out_resp, output, [0:1], response code: 0 none, 1 success, 2 overflow/underflow/invalid command, 3 never driven.
REQ-007 The block SHALL have port out_data, output, [0:31], result; nonzero only while out_resp = 1.

Function
REQ-008 The FSM SHALL have states IDLE, GET_OP2 and RESP.
REQ-009 In IDLE, a valid nonzero cmd at edge E0 SHALL capture cmd and operand 1, then go to GET_OP2.
REQ-010 In GET_OP2, edge E1 SHALL capture operand 2 regardless of req_cmd_in, register out_resp/out_data and go to RESP; response latency is two edges after the command edge.
REQ-011 In IDLE, an invalid nonzero cmd at E0 SHALL go directly to RESP with out_resp = 2 and out_data = 0; no operand cycle is consumed.
REQ-012 In RESP, outputs SHALL be held for exactly one cycle; at the next edge they SHALL return to 0.
REQ-013 At that same RESP edge, req_cmd_in SHALL be evaluated as a new E0, so back-to-back transactions have no idle gap.
REQ-014 In IDLE, cmd 0 SHALL keep the FSM in IDLE with outputs 0.
REQ-015 Add SHALL compute the 33-bit sum of unsigned operands; a carry out SHALL give out_resp = 2 and out_data = 0, otherwise out_resp = 1 with the 32-bit sum.
REQ-016 Subtract SHALL give out_resp = 2 and out_data = 0 when op1 < op2; otherwise out_resp = 1 and data op1 - op2 (equal operands give 0 with resp 1).
REQ-017 Shift left/right SHALL logically shift op1 by op2[27:31] (0..31), zero-filling, with out_resp = 1; bits shifted out are discarded without error, and the upper op2 bits are ignored.
REQ-018 With ENABLE_SHIFT = 0, cmds 5/6 SHALL be handled per REQ-011.
REQ-019 req_data_in SHALL be ignored in IDLE cycles where cmd = 0.

Reset
REQ-020 Asserting reset SHALL immediately force state IDLE, out_resp = 0 and out_data = 0, and clear the captured cmd and operands, without waiting for a clock edge.
REQ-021 Reset asserted in GET_OP2 or RESP SHALL abort the transaction; no response SHALL be produced for it afterwards.
REQ-022 After reset deassertion, the first rising edge with a valid nonzero cmd SHALL be treated as E0.

Structure
REQ-023 Shared package calc_pkg SHALL hold the command codes, response codes, state enumeration and the data width constant 32.
REQ-024 A combinational sub-module calc_alu SHALL take cmd, op1 and op2 and return resp and data; the FSM and registers SHALL stay in calc_port_responder.

Verification
REQ-025 Add: cmd 1, data 32'h0000_0001, then 32'h1FFF_FFFF -> two edges later out_resp = 1, out_data = 32'h2000_0000 for exactly one cycle.
REQ-026 Overflow: cmd 1, data 32'hFFFF_FFFF, then 32'h0000_0001 -> out_resp = 2, out_data = 0; underflow: cmd 2, 1 then 15 -> out_resp = 2, out_data = 0.
REQ-027 Invalid: cmd 3, then cmd 4, each with data 1 -> out_resp = 2, out_data = 0 one edge after each command, and the FSM back in IDLE-equivalent behaviour.
REQ-028 Shift: cmd 5, 32'h0000_0001, then 32'h0000_0023 (shift 3) -> out_data = 32'h0000_0008; cmd 6, 32'h8000_0000, then 31 -> out_data = 1, out_resp = 1.
REQ-029 Back-to-back and reset: cmd 1 issued in the RESP cycle of a prior add -> both responses are correct in consecutive windows; reset asserted in GET_OP2 -> outputs 0 immediately and no response after release.
